// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I(+M) control sequencer: owns the instruction register and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB with req/ready memory handshakes.
module multicycle_controller #(
    parameter bit HAS_M       = 1'b0,
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ready,
    input  logic        i_dmem_ready,
    output logic        o_imem_req,
    output logic        o_dmem_req,
    output logic [31:0] o_instr,
    output logic [4:0]  o_alu_opt,
    output logic        o_alu_a_in,
    output logic [1:0]  o_alu_b_in,
    output logic        o_write_reg_enable,
    output logic [1:0]  o_write_ram_flag,
    output logic        o_load_ram_enable,
    output logic [2:0]  o_read_ram_flag,
    output logic [1:0]  o_pc_condition,
    output logic        o_pc_write,
    output logic        o_retire,
    output logic        o_illegal,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SLT  = 5'b00110;
    localparam logic [4:0] ALU_SLTU = 5'b00111;
    localparam logic [4:0] ALU_SRL  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01001;
    localparam logic [4:0] ALU_JALR = 5'b01010;
    localparam logic [4:0] ALU_BEQ  = 5'b01011;
    localparam logic [4:0] ALU_BNE  = 5'b01100;
    localparam logic [4:0] ALU_BLT  = 5'b01101;
    localparam logic [4:0] ALU_BGE  = 5'b01110;
    localparam logic [4:0] ALU_BLTU = 5'b01111;
    localparam logic [4:0] ALU_BGEU = 5'b10000;
    localparam logic [4:0] ALU_LUI  = 5'b10001;
    localparam logic [4:0] ALU_MUL  = 5'b10010;

    localparam logic [3:0] LAT_M1 = 4'(MUL_LATENCY - 1);

    state_t      r_state;
    logic [31:0] r_ir;
    logic        r_imem_req;
    logic        r_dmem_req;
    logic [4:0]  r_alu_opt;
    logic        r_alu_a_in;
    logic [1:0]  r_alu_b_in;
    logic        r_write_reg_enable;
    logic [1:0]  r_write_ram_flag;
    logic        r_load_ram_enable;
    logic [2:0]  r_read_ram_flag;
    logic [1:0]  r_pc_condition;
    logic        r_pc_write;
    logic        r_retire;
    logic        r_illegal;
    logic        r_wr_pend;
    logic [1:0]  r_wram_pend;
    logic        r_is_mem;
    logic [3:0]  r_cnt;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_legal;
    logic [4:0]  w_opt;
    logic        w_a;
    logic [1:0]  w_b;
    logic        w_wr;
    logic [1:0]  w_wram;
    logic        w_lre;
    logic [2:0]  w_rflag;
    logic [1:0]  w_pcc;
    logic        w_mem;
    logic        w_mop;

    assign w_opcode = r_ir[6:0];
    assign w_f3     = r_ir[14:12];
    assign w_f7     = r_ir[31:25];

    // Decode of the latched IR; captured into the control registers on leaving DECODE.
    always_comb begin
        w_legal = 1'b1;
        w_opt   = ALU_ADD;
        w_a     = 1'b0;
        w_b     = 2'b00;
        w_wr    = 1'b0;
        w_wram  = 2'b00;
        w_lre   = 1'b0;
        w_rflag = 3'b000;
        w_pcc   = 2'b00;
        w_mem   = 1'b0;
        w_mop   = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_opt = ALU_LUI;
                w_b   = 2'b01;
                w_wr  = 1'b1;
            end
            OPC_AUIPC: begin
                w_a  = 1'b1;
                w_b  = 2'b01;
                w_wr = 1'b1;
            end
            OPC_JAL: begin
                w_a   = 1'b1;
                w_b   = 2'b11;
                w_wr  = 1'b1;
                w_pcc = 2'b10;
            end
            OPC_JALR: begin
                w_opt = ALU_JALR;
                w_b   = 2'b01;
                w_wr  = 1'b1;
                w_pcc = 2'b11;
            end
            OPC_BRANCH: begin
                w_pcc = 2'b01;
                case (w_f3)
                    3'b000:  w_opt = ALU_BEQ;
                    3'b001:  w_opt = ALU_BNE;
                    3'b100:  w_opt = ALU_BLT;
                    3'b101:  w_opt = ALU_BGE;
                    3'b110:  w_opt = ALU_BLTU;
                    3'b111:  w_opt = ALU_BGEU;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                w_b   = 2'b01;
                w_wr  = 1'b1;
                w_lre = 1'b1;
                w_mem = 1'b1;
                case (w_f3)
                    3'b000:  w_rflag = 3'b111;
                    3'b001:  w_rflag = 3'b110;
                    3'b010:  w_rflag = 3'b001;
                    3'b100:  w_rflag = 3'b011;
                    3'b101:  w_rflag = 3'b010;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                w_b   = 2'b01;
                w_mem = 1'b1;
                case (w_f3)
                    3'b000:  w_wram = 2'b11;
                    3'b001:  w_wram = 2'b10;
                    3'b010:  w_wram = 2'b01;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                w_b  = 2'b01;
                w_wr = 1'b1;
                case (w_f3)
                    3'b000: w_opt = ALU_ADD;
                    3'b010: w_opt = ALU_SLT;
                    3'b011: w_opt = ALU_SLTU;
                    3'b100: w_opt = ALU_XOR;
                    3'b110: w_opt = ALU_OR;
                    3'b111: w_opt = ALU_AND;
                    3'b001: begin
                        w_opt = ALU_SLL;
                        if (w_f7 != 7'b0000000) w_legal = 1'b0;
                    end
                    default: begin
                        if (w_f7 == 7'b0000000)      w_opt = ALU_SRL;
                        else if (w_f7 == 7'b0100000) w_opt = ALU_SRA;
                        else                         w_legal = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                w_wr = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_opt = ALU_ADD;
                        3'b001:  w_opt = ALU_SLL;
                        3'b010:  w_opt = ALU_SLT;
                        3'b011:  w_opt = ALU_SLTU;
                        3'b100:  w_opt = ALU_XOR;
                        3'b101:  w_opt = ALU_SRL;
                        3'b110:  w_opt = ALU_OR;
                        default: w_opt = ALU_AND;
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    case (w_f3)
                        3'b000:  w_opt = ALU_SUB;
                        3'b101:  w_opt = ALU_SRA;
                        default: w_legal = 1'b0;
                    endcase
                end else if (HAS_M && w_f7 == 7'b0000001) begin
                    // M codes are contiguous from mul in func3 order.
                    w_opt = ALU_MUL + {2'b00, w_f3};
                    w_mop = 1'b1;
                end else begin
                    w_legal = 1'b0;
                end
            end
            OPC_FENCE: begin
                w_opt = ALU_ADD;
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_ir               <= 32'd0;
            r_imem_req         <= 1'b0;
            r_dmem_req         <= 1'b0;
            r_alu_opt          <= 5'd0;
            r_alu_a_in         <= 1'b0;
            r_alu_b_in         <= 2'b00;
            r_write_reg_enable <= 1'b0;
            r_write_ram_flag   <= 2'b00;
            r_load_ram_enable  <= 1'b0;
            r_read_ram_flag    <= 3'b000;
            r_pc_condition     <= 2'b00;
            r_pc_write         <= 1'b0;
            r_retire           <= 1'b0;
            r_illegal          <= 1'b0;
            r_wr_pend          <= 1'b0;
            r_wram_pend        <= 2'b00;
            r_is_mem           <= 1'b0;
            r_cnt              <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (r_imem_req && i_imem_ready) begin
                        r_ir       <= i_imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_alu_opt         <= w_opt;
                        r_alu_a_in        <= w_a;
                        r_alu_b_in        <= w_b;
                        r_load_ram_enable <= w_lre;
                        r_read_ram_flag   <= w_rflag;
                        r_pc_condition    <= w_pcc;
                        r_wr_pend         <= w_wr;
                        r_wram_pend       <= w_wram;
                        r_is_mem          <= w_mem;
                        r_cnt             <= w_mop ? LAT_M1 : 4'd0;
                        r_state           <= S_EXEC;
                    end else begin
                        r_illegal <= 1'b1;
                        r_state   <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (r_is_mem) begin
                        r_dmem_req       <= 1'b1;
                        r_write_ram_flag <= r_wram_pend;
                        r_state          <= S_MEM;
                    end else begin
                        r_pc_write         <= 1'b1;
                        r_retire           <= 1'b1;
                        r_write_reg_enable <= r_wr_pend;
                        r_state            <= S_WB;
                    end
                end
                S_MEM: begin
                    if (r_dmem_req && i_dmem_ready) begin
                        r_dmem_req         <= 1'b0;
                        r_write_ram_flag   <= 2'b00;
                        r_pc_write         <= 1'b1;
                        r_retire           <= 1'b1;
                        r_write_reg_enable <= r_wr_pend;
                        r_state            <= S_WB;
                    end
                end
                S_WB: begin
                    r_pc_write         <= 1'b0;
                    r_retire           <= 1'b0;
                    r_write_reg_enable <= 1'b0;
                    r_imem_req         <= 1'b1;
                    r_state            <= S_FETCH;
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_imem_req         = r_imem_req;
    assign o_dmem_req         = r_dmem_req;
    assign o_instr            = r_ir;
    assign o_alu_opt          = r_alu_opt;
    assign o_alu_a_in         = r_alu_a_in;
    assign o_alu_b_in         = r_alu_b_in;
    assign o_write_reg_enable = r_write_reg_enable;
    assign o_write_ram_flag   = r_write_ram_flag;
    assign o_load_ram_enable  = r_load_ram_enable;
    assign o_read_ram_flag    = r_read_ram_flag;
    assign o_pc_condition     = r_pc_condition;
    assign o_pc_write         = r_pc_write;
    assign o_retire           = r_retire;
    assign o_illegal          = r_illegal;
    assign o_state            = r_state;

endmodule
